// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers (shift-add MULT, restoring DIV).
// Define MULDIV_SIGNED_EN to honour sgn with two's-complement operation.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0]   opb;
    logic               dz;
    logic [WIDTH:0]     mul_sum, div_shl, div_diff;
    logic               div_sub;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
        div_shl  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = div_shl - {1'b0, opb};
        // a shifted-out top bit means the partial remainder already exceeds any divisor;
        // this also makes b == 0 yield quotient all ones and remainder a
        div_sub  = div_shl[WIDTH] | ~div_diff[WIDTH];
        acc_nxt  = acc;
        if (state == MUL)
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        else if (state == DIV)
            acc_nxt = div_sub ? {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                              : {div_shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

`ifdef MULDIV_SIGNED_EN
    logic               sa, sb;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo, rem;

    assign mag_a = (sgn && a[WIDTH-1]) ? -a : a;
    assign mag_b = (sgn && b[WIDTH-1]) ? -b : b;

    always_comb begin
        prod_s = (sa ^ sb) ? -acc_nxt : acc_nxt;
        quo    = acc_nxt[WIDTH-1:0];
        rem    = acc_nxt[2*WIDTH-1:WIDTH];
        if (state == MUL) begin
            res_hi = prod_s[2*WIDTH-1:WIDTH];
            res_lo = prod_s[WIDTH-1:0];
        end else begin
            res_lo = dz ? {WIDTH{1'b1}} : ((sa ^ sb) ? -quo : quo);
            res_hi = sa ? -rem : rem;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sa <= 1'b0;
            sb <= 1'b0;
        end else if (state == IDLE && start && !op[1]) begin
            sa <= sgn & a[WIDTH-1];
            sb <= sgn & b[WIDTH-1];
        end
    end
`else
    logic unused_sgn;
    assign unused_sgn = sgn;
    assign mag_a  = a;
    assign mag_b  = b;
    assign res_hi = acc_nxt[2*WIDTH-1:WIDTH];
    assign res_lo = acc_nxt[WIDTH-1:0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            opb         <= '0;
            dz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            2'b00, 2'b01: begin
                                acc         <= {{WIDTH{1'b0}}, mag_a};
                                opb         <= mag_b;
                                dz          <= (b == '0);
                                cnt         <= CW'(WIDTH);
                                div_by_zero <= 1'b0;
                                busy        <= 1'b1;
                                state       <= op[0] ? DIV : MUL;
                            end
                            2'b10:   hi <= a;
                            default: lo <= a;
                        endcase
                    end
                end
                MUL, DIV: begin
                    acc <= acc_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                        if (state == DIV) div_by_zero <= dz;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit (WIDTH = 32) against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    opv;
    logic          sgn;
    logic [W-1:0]  a, b;
    logic          busy, done, div_by_zero;
    logic [W-1:0]  hi, lo;

    int nchk = 0;
    int nerr = 0;

    logic [W-1:0] mhi, mlo;
    logic         mdz;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(opv), .sgn(sgn),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: results from plain integer arithmetic
    task automatic model(input logic [1:0] o, input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [63:0] p;
        longint      sa, sb, q, r;
        sa = longint'(av);
        sb = longint'(bv);
`ifdef MULDIV_SIGNED_EN
        if (s) begin
            sa = longint'($signed(av));
            sb = longint'($signed(bv));
        end
`endif
        case (o)
            2'b10: mhi = av;
            2'b11: mlo = av;
            2'b00: begin
                p   = 64'(sa * sb);
                mhi = p[63:32];
                mlo = p[31:0];
                mdz = 1'b0;
            end
            default: begin
                mdz = (bv == 0);
                if (bv == 0) begin
                    mlo = '1;
                    mhi = av;
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    mlo = q[31:0];
                    mhi = r[31:0];
                end
            end
        endcase
    endtask

    // Called at a negedge with the FSM idle; returns at a negedge with the FSM idle again.
    task automatic run(input string tag, input logic [1:0] o, input logic s,
                       input logic [W-1:0] av, input logic [W-1:0] bv,
                       input bit scramble, input bit poke);
        int busy_n, done_n, done_cyc;
        bit held;
        logic [W-1:0] ohi, olo;
        ohi = mhi; olo = mlo;
        start = 1'b1; opv = o; sgn = s; a = av; b = bv;
        @(posedge clk);
        model(o, s, av, bv);
        if (o[1]) begin
            @(negedge clk);
            start = 1'b0;
            chk({tag, "_busy"}, 64'(busy), 64'(0));
            chk({tag, "_done"}, 64'(done), 64'(0));
            chk({tag, "_hi"}, 64'(hi), 64'(mhi));
            chk({tag, "_lo"}, 64'(lo), 64'(mlo));
            return;
        end
        busy_n = 0; done_n = 0; done_cyc = 0; held = 1;
        for (int c = 1; c <= W + 1; c++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin done_n++; done_cyc = c; end
            if (c <= W && (hi !== ohi || lo !== olo)) held = 0;
            start = 1'b0;
            if (c == 3) begin
                if (scramble) begin a = '0; b = '0; end
                else begin a = $urandom; b = $urandom; end
                if (poke) begin start = 1'b1; opv = 2'b10; end
            end
        end
        @(negedge clk);
        chk({tag, "_busycnt"}, 64'(busy_n), 64'(W));
        chk({tag, "_donecnt"}, 64'(done_n), 64'(1));
        chk({tag, "_donecyc"}, 64'(done_cyc), 64'(W + 1));
        chk({tag, "_held"}, 64'(held), 64'(1));
        chk({tag, "_idle"}, 64'({busy, done}), 64'(0));
        chk({tag, "_hi"}, 64'(hi), 64'(mhi));
        chk({tag, "_lo"}, 64'(lo), 64'(mlo));
        chk({tag, "_dz"}, 64'(div_by_zero), 64'(mdz));
    endtask

    initial begin
        bit seen;
        logic [1:0] o;
        logic [W-1:0] bv;
        reset = 1'b1; start = 1'b0; opv = '0; sgn = 1'b0; a = '0; b = '0;
        mhi = '0; mlo = '0; mdz = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", 64'({busy, done, div_by_zero}), 64'(0));
        chk("rst_hilo", {hi, lo}, 64'(0));
        reset = 1'b0;
        @(negedge clk);

        run("mul_ff", 2'b00, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        chk("mul_ff_exp", {hi, lo}, 64'hFFFFFFFE_00000001);
        run("div_100_7", 2'b01, 1'b0, 32'd100, 32'd7, 1, 0);
        chk("div_100_7_exp", {hi, lo}, {32'd2, 32'd14});
        run("div_by0", 2'b01, 1'b0, 32'd5, 32'd0, 0, 0);
        chk("div_by0_exp", 64'({div_by_zero, hi, lo}), {1'b1, 32'd5, 32'hFFFFFFFF});
        run("mul_3_4", 2'b00, 1'b0, 32'd3, 32'd4, 0, 0);
        chk("mul_3_4_exp", 64'({div_by_zero, hi, lo}), {1'b0, 32'd0, 32'd12});
        run("mthi", 2'b10, 1'b0, 32'h1234, 32'd0, 0, 0);
        run("mul_poke", 2'b00, 1'b0, 32'd77, 32'd1000, 0, 1);
        run("mtlo", 2'b11, 1'b0, 32'hCAFE, 32'd0, 0, 0);

        // mid-operation reset
        start = 1'b1; opv = 2'b00; a = 32'hDEAD; b = 32'hBEEF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_busy", 64'({busy, done, div_by_zero}), 64'(0));
        chk("midrst_hilo", {hi, lo}, 64'(0));
        mhi = '0; mlo = '0; mdz = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        chk("midrst_nodone", 64'(seen), 64'(0));
        run("div_9_3", 2'b01, 1'b0, 32'd9, 32'd3, 0, 0);
        chk("div_9_3_exp", {hi, lo}, {32'd0, 32'd3});

`ifdef MULDIV_SIGNED_EN
        run("sdiv", 2'b01, 1'b1, -32'sd7, 32'd2, 0, 0);
        chk("sdiv_exp", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run("smul", 2'b00, 1'b1, -32'sd3, 32'd5, 0, 0);
        chk("smul_exp", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
        run("sdiv_ovf", 2'b01, 1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        chk("sdiv_ovf_exp", {hi, lo}, 64'h00000000_80000000);
`else
        run("usgn_div", 2'b01, 1'b1, 32'hFFFFFFF9, 32'd2, 0, 0);
        chk("usgn_div_exp", {hi, lo}, 64'h00000001_7FFFFFFC);
`endif

        for (int i = 0; i < 120; i++) begin
            o = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       bv = '0;
                1, 2:    bv = 32'($urandom_range(1, 20));
                3:       bv = '1;
                default: bv = $urandom;
            endcase
            run("rnd", o, 1'($urandom), $urandom, bv, 0, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO register width in bits; legal values 8 to 64.
REQ-002 Port clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port start  input  1  request strobe, sampled on rising clk.
REQ-005 Port op  input  2  operation: 00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
REQ-006 Port sgn  input  1  signed-operation request; honoured only per REQ-027.
REQ-007 Port a  input  WIDTH  operand A (multiplicand / dividend / move source).
REQ-008 Port b  input  WIDTH  operand B (multiplier / divisor).
REQ-009 Port busy  output  1  iterative operation in progress.
REQ-010 Port done  output  1  one-cycle pulse: HI/LO hold a new MULT/DIV result.
REQ-011 Port hi  output  WIDTH  HI register: upper product half, or remainder.
REQ-012 Port lo  output  WIDTH  LO register: lower product half, or quotient.
REQ-013 Port div_by_zero  output  1  last accepted DIV had b == 0.

Function
REQ-014 The FSM SHALL have states IDLE, MUL, DIV, DONE; busy = (state is MUL or DIV); done = (state is DONE).
REQ-015 start SHALL be accepted only in IDLE; it SHALL be ignored in MUL, DIV and DONE.
REQ-016 On an accepted MULT/DIV edge k, a and b SHALL be captured, an iteration counter SHALL be loaded with WIDTH, and the FSM SHALL enter MUL or DIV; later changes on a and b SHALL have no effect.
REQ-017 MUL SHALL be shift-add, one multiplier bit per cycle; DIV SHALL be restoring division, one quotient bit per cycle.
REQ-018 The last iteration SHALL occur on edge k+WIDTH; that edge SHALL write hi/lo and enter DONE, so done is high for exactly the cycle after edge k+WIDTH.
REQ-019 DONE SHALL return to IDLE on the next edge unconditionally, so a new start is accepted at earliest on edge k+WIDTH+2.
REQ-020 hi and lo SHALL hold their previous values throughout MUL and DIV; partial results SHALL never be visible.
REQ-021 MULT SHALL produce the full 2*WIDTH-bit product, with the upper half in hi and the lower half in lo.
REQ-022 DIV SHALL produce the quotient in lo and the remainder in hi.
REQ-023 DIV with b == 0 SHALL still take WIDTH cycles, then set lo = all ones, hi = a, and div_by_zero = 1.
REQ-024 div_by_zero SHALL be cleared on the next accepted MULT or DIV start.
REQ-025 MTHI/MTLO accepted in IDLE SHALL write a into hi or lo on that edge, SHALL leave the FSM in IDLE, and SHALL not assert busy or done.

Reset
REQ-026 Asserting reset SHALL immediately force state IDLE, counter 0, busy = 0, done = 0, hi = 0, lo = 0, div_by_zero = 0. A mid-operation reset SHALL abort the operation and produce no done pulse.

Configuration
REQ-027 With macro MULDIV_SIGNED_EN defined, sgn = 1 SHALL select two's-complement operation:
- operands are converted to magnitudes at capture and results are sign-corrected on the write edge;
- latency is unchanged;
- the quotient truncates toward zero and the remainder takes the sign of the dividend;
- most-negative divided by -1 gives lo = most-negative, hi = 0.
Without the macro, sgn SHALL be ignored, all operations SHALL be unsigned, and no sign-correction logic SHALL be present.

Verification (WIDTH = 32)
REQ-028 MULT a=0xFFFFFFFF b=0xFFFFFFFF -> busy for cycles 1..32, done in cycle 33, hi=0xFFFFFFFE, lo=0x00000001.
REQ-029 DIV a=100 b=7, with a/b changed to 0 at cycle 3 -> lo=14, hi=2, div_by_zero=0.
REQ-030 DIV a=5 b=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1; a following MULT 3*4 -> div_by_zero=0, lo=12, hi=0.
REQ-031 MTHI a=0x1234, start pulsed during a later MULT busy period -> hi=0x1234 immediately, busy never set by the MTHI, the second start ignored, and only one done pulse.
REQ-032 MULT started, reset asserted at cycle 10 -> busy=0, hi=lo=0 at once, no done pulse, and a fresh DIV 9/3 then gives lo=3, hi=0.
REQ-033 With MULDIV_SIGNED_EN, sgn=1, DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
